ucsbece154a_uart_tx_mmio: RTL

Memory-mapped UART transmitter that sits downstream of the single-cycle MIPS core on the data-memory bus, alongside the data memory. It consumes `sw` stores to its address window, buffers the bytes in a small FIFO, and serialises them as 8N1 frames on `tx_o`. This gives `ucsbece154a_top` programs a visible output channel beyond register and RAM state.

---
 rtl/ucsbece154a_uart_pkg.sv | 30 +++
 rtl/ucsbece154a_sync_fifo.sv | 74 +++++++
 rtl/ucsbece154a_uart_tx_mmio.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ucsbece154a_uart_pkg.sv
// rtl/ucsbece154a_uart_pkg.sv - shared constants for the MMIO UART transmitter
//
// Purpose: FSM state encoding, register offsets inside the 8-byte window and
// the STATUS register bit positions, shared by the transmitter top level.
package ucsbece154a_uart_pkg;

  // Transmit FSM states; encoding is fixed so STATUS/debug views stay stable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Byte offsets of the two registers; only bit 2 distinguishes them.
  localparam logic [2:0] TXDATA_OFF = 3'd0;
  localparam logic [2:0] STATUS_OFF = 3'd4;

  // STATUS register fields.
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 7;

  // Frame length in bit periods: start + 8 data + stop.
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/ucsbece154a_sync_fifo.sv
// rtl/ucsbece154a_sync_fifo.sv - single-clock FIFO with occupancy count
//
// Purpose: small byte buffer between the store port and the serialiser.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   push, wdata       - write request and data; ignored when full
//   pop               - read request; ignored when empty
//   rdata             - current head entry (valid when !empty)
//   full, empty       - occupancy flags reflecting state after the last edge
//   count             - number of stored entries, 0..DEPTH
module ucsbece154a_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  // Acceptance is judged on the pre-edge flags only, so a push into a full
  // FIFO is refused even when a pop frees a slot on the same edge.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rdata = mem[rd_ptr];

  // Storage array carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH (a power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ucsbece154a_uart_tx_mmio.sv
// rtl/ucsbece154a_uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter
//
// Purpose: sits on the core's data-memory bus next to dmem. Stores to
// TXDATA queue a byte; the FSM shifts queued bytes out LSB first as 8N1
// frames. STATUS exposes FIFO/FSM state and a sticky overflow flag.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   a_i         - data-bus address (same value driven to dmem)
//   we_i, wd_i  - store enable and store data
//   sel_o       - address falls inside the 8-byte window (combinational)
//   rd_o        - read data for the window (combinational)
//   tx_o        - registered serial output, idles high
//   busy_o      - frame in progress or bytes still queued
module ucsbece154a_uart_tx_mmio
  import ucsbece154a_uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic        sel_o,
  output logic [31:0] rd_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int                BW       = $clog2(CLKS_PER_BIT);
  localparam int                CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0]     BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------
  // Address decode and register access
  // ---------------------------------------------------------------------
  logic        is_status;
  logic        push_req;
  logic        ovf_clr;
  logic        overflow;
  logic [31:0] status;
  logic        unused_bits;

  assign sel_o     = (a_i[31:3] == BASE_ADDR[31:3]);
  assign is_status = (a_i[2] == STATUS_OFF[2]);
  assign push_req  = we_i & sel_o & ~is_status;
  assign ovf_clr   = we_i & sel_o & is_status & wd_i[STAT_OVF];

  // Byte lanes and the low address bits play no part in this window.
  assign unused_bits = ^{a_i[1:0], wd_i[31:8], TXDATA_OFF};

  // ---------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  ucsbece154a_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .wdata (wd_i[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------------
  // Sticky overflow: a refused push sets it; a set on the same edge as a
  // clear wins.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req & fifo_full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------
  uart_state_e   state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_q;
  logic          baud_done;

  assign baud_done = (baud == '0);

  // The head is taken either from IDLE or at the very last STOP cycle, the
  // latter giving back-to-back frames with no idle gap.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE) begin
        fifo_pop = 1'b1;
      end else if (state == STOP && baud_done) begin
        fifo_pop = 1'b1;
      end
    end
  end

  // tx_q is updated together with every state change, so the line value is
  // always a flop output and already correct on the first cycle of a state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            state <= START;
            baud  <= BAUD_MAX;
            shift <= fifo_head;
            tx_q  <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state   <= DATA;
            baud    <= BAUD_MAX;
            bit_idx <= '0;
            tx_q    <= shift[0];
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud    <= BAUD_MAX;
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              // Next bit is the one about to land in shift[0].
              tx_q <= shift[1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            if (fifo_pop) begin
              state <= START;
              baud  <= BAUD_MAX;
              shift <= fifo_head;
              tx_q  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state != IDLE) | ~fifo_empty;

  // ---------------------------------------------------------------------
  // STATUS assembly and read mux; TXDATA reads as zero.
  // ---------------------------------------------------------------------
  always_comb begin
    status                             = '0;
    status[STAT_FULL]                  = fifo_full;
    status[STAT_EMPTY]                 = fifo_empty;
    status[STAT_BUSY]                  = (state != IDLE);
    status[STAT_OVF]                   = overflow;
    status[STAT_CNT_MSB:STAT_CNT_LSB]  = 4'(fifo_count);
  end

  assign rd_o = (sel_o & is_status) ? status : 32'h0000_0000;

endmodule
